// File: rtl/fifo_demo_pkg.sv
// rtl/fifo_demo_pkg.sv - shared widths, read-controller states and helpers for the ip_FIFO demo
package fifo_demo_pkg;

  localparam int FIFO_DW   = 8;
  localparam int FIFO_AW   = 8;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } rd_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - FIFO read-side flags/data plus burst observation outputs
interface fifo_rd_ctrl_if import fifo_demo_pkg::*; #(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) ();

  logic                 rd_full;
  logic                 rd_empty;
  logic [AW-1:0]        rd_usedw;
  logic [DW-1:0]        fifo_q;
  logic                 fifo_rd_req;
  logic [DW-1:0]        rd_data;
  logic                 rd_data_vld;
  logic                 rd_busy;
  logic                 burst_done;
  logic [AW:0]          burst_len;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    input  rd_full, rd_empty, rd_usedw, fifo_q,
    output fifo_rd_req, rd_data, rd_data_vld, rd_busy, burst_done, burst_len, err_cnt
  );

  modport slave (
    output rd_full, rd_empty, rd_usedw, fifo_q,
    input  fifo_rd_req, rd_data, rd_data_vld, rd_busy, burst_done, burst_len, err_cnt
  );

endinterface

// File: rtl/fifo_rd_pipe.sv
// rtl/fifo_rd_pipe.sv - tracks issued reads over the RD_LAT data latency and registers each returned word
module fifo_rd_pipe #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [DW-1:0] fifo_q,
  output logic [DW-1:0] rd_data,
  output logic          rd_data_vld,
  output logic          cap_en,
  output logic          in_flight
);

  logic [RD_LAT-1:0] req_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sr      <= '0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      req_sr[0] <= rd_req;
      for (int i = 1; i < RD_LAT; i++) begin
        req_sr[i] <= req_sr[i-1];
      end
      rd_data_vld <= cap_en;
      if (cap_en) begin
        rd_data <= fifo_q;
      end
    end
  end

  // fifo_q is valid exactly when the oldest tracked request reaches the tail
  assign cap_en    = req_sr[RD_LAT-1];
  assign in_flight = |req_sr;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - waits for FIFO full, settles, then drains it in one burst until empty
// Optional pattern check of the drained words is built when FIFO_RD_CHECK_EN is defined.
module fifo_rd_ctrl import fifo_demo_pkg::*; #(
  parameter int DW         = FIFO_DW,
  parameter int AW         = FIFO_AW,
  parameter int SETTLE_CYC = 10,
  parameter int RD_LAT     = 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  fifo_rd_ctrl_if.master  bus
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  rd_state_e       state, state_nxt;
  logic [SC_W-1:0] settle_cnt;
  logic [AW:0]     word_cnt;
  logic [AW:0]     burst_len;
  logic            burst_done;
  logic            rd_req;
  logic            settle_start;
  logic            cap_en;
  logic            in_flight;
  logic [DW-1:0]   rd_data;
  logic            rd_data_vld;
  logic            unused_usedw;

  assign settle_start = (state == IDLE) && bus.rd_full;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read request is combinational on rd_empty so an empty FIFO is never popped
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_full) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SC_W'(SETTLE_CYC - 1)) state_nxt = READ;
      end
      READ: begin
        rd_req = !bus.rd_empty;
        if (bus.rd_empty && !in_flight) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle_cnt <= '0;
      word_cnt   <= '0;
      burst_len  <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= (state == DONE);
      if (state == DONE) begin
        burst_len <= word_cnt;
      end
      if (state != SETTLE) begin
        settle_cnt <= '0;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (settle_start) begin
        word_cnt <= '0;
      end else if (cap_en) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  fifo_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .rd_req      (rd_req),
    .fifo_q      (bus.fifo_q),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .cap_en      (cap_en),
    .in_flight   (in_flight)
  );

`ifdef FIFO_RD_CHECK_EN
  logic [DW-1:0]        exp_val;
  logic [ERR_CNT_W-1:0] err_cnt;

  // The writer fills an incrementing pattern starting at 0 for every burst
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      exp_val <= '0;
      err_cnt <= '0;
    end else begin
      if (settle_start) begin
        exp_val <= '0;
      end else if (rd_data_vld) begin
        exp_val <= exp_val + 1'b1;
      end
      if (rd_data_vld && (rd_data != exp_val)) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  assign bus.err_cnt = err_cnt;
`else
  assign bus.err_cnt = '0;
`endif

  assign unused_usedw    = ^bus.rd_usedw;
  assign bus.fifo_rd_req = rd_req;
  assign bus.rd_data     = rd_data;
  assign bus.rd_data_vld = rd_data_vld;
  assign bus.rd_busy     = (state != IDLE);
  assign bus.burst_done  = burst_done;
  assign bus.burst_len   = burst_len;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized bench: RD_LAT=1 and RD_LAT=2 controllers drained from model FIFOs
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rd_full;

  // model FIFOs: bench writes mem/wptr, the posedge process pops rptr
  logic [7:0] mem [2][1024];
  int         wptr [2];
  int         rptr [2];
  logic [7:0] st1 [2];
  logic [7:0] st2 [2];
  int         cyc;

  logic       req_w  [2];
  logic       vld_w  [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [7:0] data_w [2];
  logic [8:0] len_w  [2];
  logic [15:0] err_w [2];

  int   req_n [2];
  int   req_rise [2];
  int   req_rise_cyc [2];
  int   unf [2];
  int   vld_n [2];
  int   vld_rise_cyc [2];
  int   vld_last_cyc [2];
  int   done_n [2];
  int   done_cyc [2];
  int   done_len [2];
  logic req_prev [2];
  logic vld_prev [2];
  logic [7:0] cap [2][4096];

  int n_chk;
  int n_fail;
  int exp_err;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_rd_ctrl_if #(.DW(8), .AW(8)) bus ();

    assign bus.rd_full  = rd_full;
    assign bus.rd_empty = (wptr[g] == rptr[g]);
    assign bus.rd_usedw = 8'(wptr[g] - rptr[g]);
    assign bus.fifo_q   = (g == 0) ? st1[g] : st2[g];

    assign req_w[g]  = bus.fifo_rd_req;
    assign vld_w[g]  = bus.rd_data_vld;
    assign busy_w[g] = bus.rd_busy;
    assign done_w[g] = bus.burst_done;
    assign data_w[g] = bus.rd_data;
    assign len_w[g]  = bus.burst_len;
    assign err_w[g]  = bus.err_cnt;

    fifo_rd_ctrl #(
      .DW         (8),
      .AW         (8),
      .SETTLE_CYC (10),
      .RD_LAT     (g + 1)
    ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus.master)
    );
  end

  // FIFO IP behaviour: word appears one clock after the request, plus one more stage for RD_LAT=2
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (req_w[g] && (wptr[g] != rptr[g])) begin
        st1[g]  <= mem[g][rptr[g] % 1024];
        rptr[g] <= rptr[g] + 1;
      end
      st2[g] <= st1[g];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      req_prev[g] <= req_w[g];
      vld_prev[g] <= vld_w[g];
      if (req_w[g]) begin
        req_n[g] <= req_n[g] + 1;
        if (req_prev[g] !== 1'b1) begin
          req_rise[g]     <= req_rise[g] + 1;
          req_rise_cyc[g] <= cyc;
        end
        if (wptr[g] == rptr[g]) unf[g] <= unf[g] + 1;
      end
      if (vld_w[g]) begin
        cap[g][vld_n[g] % 4096] <= data_w[g];
        vld_n[g]        <= vld_n[g] + 1;
        vld_last_cyc[g] <= cyc;
        if (vld_prev[g] !== 1'b1) vld_rise_cyc[g] <= cyc;
      end
      if (done_w[g]) begin
        done_n[g]   <= done_n[g] + 1;
        done_len[g] <= int'(len_w[g]);
        done_cyc[g] <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("%s_req[%0d]", tag, g),  int'(req_w[g]),  0);
      check_eq($sformatf("%s_data[%0d]", tag, g), int'(data_w[g]), 0);
      check_eq($sformatf("%s_vld[%0d]", tag, g),  int'(vld_w[g]),  0);
      check_eq($sformatf("%s_busy[%0d]", tag, g), int'(busy_w[g]), 0);
      check_eq($sformatf("%s_done[%0d]", tag, g), int'(done_w[g]), 0);
      check_eq($sformatf("%s_len[%0d]", tag, g),  int'(len_w[g]),  0);
      check_eq($sformatf("%s_err[%0d]", tag, g),  int'(err_w[g]),  0);
    end
  endtask

  task automatic load_fifos(input int n, input bit rnd, input int bad_idx, output logic [7:0] d [256]);
    for (int i = 0; i < 256; i++) begin
      d[i] = rnd ? 8'($urandom) : 8'(i);
      if (i == bad_idx) d[i] = 8'hAA;
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < n; i++) mem[g][(wptr[g] + i) % 1024] = d[i];
      wptr[g] = wptr[g] + n;
    end
  endtask

  task automatic run_burst(input int n, input bit rnd, input int bad_idx);
    logic [7:0] d [256];
    int s_req[2], s_rise[2], s_unf[2], s_vld[2], s_done[2];
    int t_full, mm, ok;
    load_fifos(n, rnd, bad_idx, d);
    for (int g = 0; g < 2; g++) begin
      s_req[g] = req_n[g];  s_rise[g] = req_rise[g]; s_unf[g] = unf[g];
      s_vld[g] = vld_n[g];  s_done[g] = done_n[g];
    end
    @(negedge clk);
    rd_full = 1'b1;
    t_full  = cyc;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    rd_full = 1'b0;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done_n[0] > s_done[0] && done_n[1] > s_done[1]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("burst_timeout", ok, 1);
    repeat (3) @(negedge clk);
`ifdef FIFO_RD_CHECK_EN
    for (int i = 0; i < n; i++) begin
      if (d[i] != 8'(i) && exp_err < 65535) exp_err++;
    end
`endif
    for (int g = 0; g < 2; g++) begin
      mm = 0;
      for (int i = 0; i < n; i++) begin
        if (cap[g][(s_vld[g] + i) % 4096] !== d[i]) mm++;
      end
      check_eq($sformatf("req_rises[%0d]", g),   req_rise[g] - s_rise[g], 1);
      check_eq($sformatf("req_first[%0d]", g),   req_rise_cyc[g] - t_full, 11);
      check_eq($sformatf("req_cycles[%0d]", g),  req_n[g] - s_req[g], n);
      check_eq($sformatf("underflow[%0d]", g),   unf[g] - s_unf[g], 0);
      check_eq($sformatf("vld_latency[%0d]", g), vld_rise_cyc[g] - req_rise_cyc[g], g + 2);
      check_eq($sformatf("vld_count[%0d]", g),   vld_n[g] - s_vld[g], n);
      check_eq($sformatf("data_bad[%0d]", g),    mm, 0);
      check_eq($sformatf("done_count[%0d]", g),  done_n[g] - s_done[g], 1);
      check_eq($sformatf("burst_len[%0d]", g),   done_len[g], n);
      check_eq($sformatf("vld_before_done[%0d]", g), int'(vld_last_cyc[g] < done_cyc[g]), 1);
      check_eq($sformatf("err_cnt[%0d]", g),     int'(err_w[g]), exp_err);
      check_eq($sformatf("idle_busy[%0d]", g),   int'(busy_w[g]), 0);
    end
  endtask

  task automatic reset_mid_burst();
    logic [7:0] d [256];
    int s_vld0, s_req[2], s_done[2], ok;
    load_fifos(256, 1'b0, -1, d);
    s_vld0 = vld_n[0];
    @(negedge clk);
    rd_full = 1'b1;
    repeat (5) @(negedge clk);
    rd_full = 1'b0;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      if (vld_n[0] - s_vld0 >= 50) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("word50_timeout", ok, 1);
    #2 rst_n = 1'b0;
    #1 check_quiet("async_rst");
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) wptr[g] = rptr[g];
    exp_err = 0;
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      s_req[g]  = req_n[g];
      s_done[g] = done_n[g];
    end
    repeat (30) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("post_rst_req[%0d]", g),  req_n[g] - s_req[g], 0);
      check_eq($sformatf("post_rst_done[%0d]", g), done_n[g] - s_done[g], 0);
      check_eq($sformatf("post_rst_busy[%0d]", g), int'(busy_w[g]), 0);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_err = 0;
    rst_n   = 1'b0;
    rd_full = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_burst(256, 1'b0, -1);
    run_burst(100, 1'b0, -1);
    run_burst(256, 1'b0, 17);
    run_burst(256, 1'b0, -1);
    repeat (3) run_burst(int'($urandom_range(30, 256)), 1'($urandom_range(0, 1)), -1);
    reset_mid_burst();
    run_burst(256, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
